// File: rtl/fetch_prefetch_queue_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_prefetch_queue_if                                         |
// | Purpose  : Instruction-memory and decode handshake bundle for the fetch    |
// |            prefetch queue. master = fetch side, slave = memory/decode side.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface fetch_prefetch_queue_if #(
    parameter int XLEN = 32
) ();
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready
    );
endinterface
`default_nettype wire

// File: rtl/fetch_prefetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_prefetch_queue                                            |
// | Purpose  : In-order instruction prefetch queue with credit-based fetch,    |
// |            back-pressure and redirect flush with stale-response dropping.  |
// |            Optional macro FETCH_MISALIGN_CHECK_EN flags misaligned targets.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module fetch_prefetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    fetch_prefetch_queue_if.master bus,
    input  logic                   set_PC,
    input  logic [XLEN-1:0]        new_PC,
    output logic [$clog2(DEPTH):0] occupancy
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic                   instr_misaligned
`endif
);
    localparam int                c_AW      = $clog2(DEPTH);
    localparam int                c_CW      = c_AW + 1;
    localparam int                c_SW      = c_CW + 1;
    localparam logic [c_SW-1:0]   c_DEPTH_S = c_SW'(DEPTH);
    localparam logic [c_CW-1:0]   c_FULL    = c_CW'(DEPTH);

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_q_data [DEPTH];
    logic [XLEN-1:0] r_q_pc   [DEPTH];
    logic [XLEN-1:0] r_t_pc   [DEPTH];
    logic [c_AW-1:0] r_q_rd, r_q_wr, r_t_rd, r_t_wr;
    logic [c_CW-1:0] r_q_cnt, r_out, r_drop;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic            r_q_mis [DEPTH];
    logic            r_halt;
    logic            w_target_mis;
`endif

    logic [c_SW-1:0] w_sum;
    logic            w_halt;
    logic            w_req_valid, w_req_fire, w_resp, w_drop_resp, w_push, w_pop;
    logic [XLEN-1:0] w_target;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign w_halt       = r_halt;
    assign w_target     = new_PC;
    assign w_target_mis = (new_PC[1:0] != 2'b00);
`else
    assign w_halt       = 1'b0;
    assign w_target     = new_PC & ~XLEN'(3);
`endif

    // Credit covers both queued entries and every in-flight request, stale or not.
    assign w_sum       = {1'b0, r_q_cnt} + {1'b0, r_out};
    assign w_req_valid = reset & ~set_PC & ~w_halt & (w_sum < c_DEPTH_S);
    assign w_req_fire  = w_req_valid & bus.imem_req_ready;
    assign w_resp      = bus.imem_resp_valid;
    assign w_drop_resp = w_resp & (r_drop != '0);
    assign w_push      = w_resp & (r_drop == '0) & ~set_PC;
    assign w_pop       = (r_q_cnt != '0) & bus.instr_ready & ~set_PC;

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_fetch_pc;
    assign bus.instr_valid    = (r_q_cnt != '0);
    assign bus.instr          = r_q_data[r_q_rd];
    assign bus.instr_pc       = r_q_pc[r_q_rd];
    assign occupancy          = r_q_cnt;
`ifdef FETCH_MISALIGN_CHECK_EN
    assign instr_misaligned   = (r_q_cnt != '0) & r_q_mis[r_q_rd];
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fetch_pc <= RESET_PC;
            r_q_rd     <= '0;
            r_q_wr     <= '0;
            r_t_rd     <= '0;
            r_t_wr     <= '0;
            r_q_cnt    <= '0;
            r_out      <= '0;
            r_drop     <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            r_halt     <= 1'b0;
`endif
            for (int i = 0; i < DEPTH; i++) begin
                r_q_data[i] <= '0;
                r_q_pc[i]   <= '0;
                r_t_pc[i]   <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
                r_q_mis[i]  <= 1'b0;
`endif
            end
        end else begin
            r_out <= r_out + c_CW'(w_req_fire) - c_CW'(w_resp);
            if (set_PC) begin
                // Everything still in flight after this edge belongs to the old path.
                r_fetch_pc <= w_target;
                r_drop     <= r_out - c_CW'(w_resp);
                r_q_rd     <= '0;
                r_t_rd     <= '0;
                r_t_wr     <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
                r_halt     <= w_target_mis;
                if (w_target_mis) begin
                    r_q_data[0] <= XLEN'(32'h0000_0013);
                    r_q_pc[0]   <= new_PC;
                    r_q_mis[0]  <= 1'b1;
                    r_q_wr      <= c_AW'(1);
                    r_q_cnt     <= c_CW'(1);
                end else begin
                    r_q_wr  <= '0;
                    r_q_cnt <= '0;
                end
`else
                r_q_wr     <= '0;
                r_q_cnt    <= '0;
`endif
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc     <= r_fetch_pc + XLEN'(4);
                    r_t_pc[r_t_wr] <= r_fetch_pc;
                    r_t_wr         <= r_t_wr + c_AW'(1);
                end
                if (w_drop_resp) begin
                    r_drop <= r_drop - c_CW'(1);
                end
                if (w_push) begin
                    r_q_data[r_q_wr] <= bus.imem_resp_data;
                    r_q_pc[r_q_wr]   <= r_t_pc[r_t_rd];
`ifdef FETCH_MISALIGN_CHECK_EN
                    r_q_mis[r_q_wr]  <= 1'b0;
`endif
                    r_q_wr           <= r_q_wr + c_AW'(1);
                    r_t_rd           <= r_t_rd + c_AW'(1);
                end
                if (w_pop) begin
                    r_q_rd <= r_q_rd + c_AW'(1);
                end
                r_q_cnt <= r_q_cnt + c_CW'(w_push) - c_CW'(w_pop);
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clock) begin
        if (reset) begin
            assert (!(w_push && !w_pop && (r_q_cnt == c_FULL)));
        end
    end
`endif
endmodule
`default_nettype wire
